// File: rtl/blink_word_loader.sv
// Word-serial host front-end for the Blink-128/128 iterative core.
// Collects a framed word stream (header, optional round-key block, tweak,
// data) into the core's wide inputs, waits CORE_LAT cycles for the core,
// then returns the captured ciphertext as N/W words with m_last marking the end.
module blink_word_loader #(
    parameter int unsigned N         = 128,
    parameter int unsigned TWEAK_LEN = 128,
    parameter int unsigned ROUND     = 16,
    parameter int unsigned W         = 32,
    parameter int unsigned CORE_LAT  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W-1:0]           s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [W-1:0]           m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   err,
    output logic                   core_enc,
    output logic [N*ROUND/2-1:0]   core_K0,
    output logic [TWEAK_LEN-1:0]   core_T,
    output logic [N-1:0]           core_P,
    input  logic [N-1:0]           core_C
);

    localparam int unsigned KB   = N * ROUND / 2;
    localparam int unsigned KW   = KB / W;
    localparam int unsigned TW   = TWEAK_LEN / W;
    localparam int unsigned DW   = N / W;
    localparam int unsigned MAXW = (KW > TW) ? ((KW > DW) ? KW : DW)
                                             : ((TW > DW) ? TW : DW);
    localparam int unsigned CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int unsigned LW   = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam int unsigned OW   = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_TWEAK,
        S_DATA,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [LW-1:0]   r_wait;
    logic [OW-1:0]   r_oidx;
    logic [N-1:0]    r_out;
    logic            r_key_loaded;
    logic            r_err;
    logic            r_enc;
    logic [KB-1:0]   r_K0;
    logic [TWEAK_LEN-1:0] r_T;
    logic [N-1:0]    r_P;
    logic            w_s_fire;
    logic            w_m_fire;

    assign s_ready  = (r_state == S_IDLE) || (r_state == S_KEY) ||
                      (r_state == S_TWEAK) || (r_state == S_DATA);
    assign m_valid  = (r_state == S_OUT);
    assign busy     = (r_state != S_IDLE);
    assign m_data   = r_out[W*r_oidx +: W];
    assign m_last   = (r_state == S_OUT) && (r_oidx == OW'(DW - 1));
    assign err      = r_err;
    assign core_enc = r_enc;
    assign core_K0  = r_K0;
    assign core_T   = r_T;
    assign core_P   = r_P;
    assign w_s_fire = s_valid && s_ready;
    assign w_m_fire = m_valid && m_ready;

    // Frame sequencer: word capture into core inputs, core wait, result drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wait       <= '0;
            r_oidx       <= '0;
            r_out        <= '0;
            r_key_loaded <= 1'b0;
            r_err        <= 1'b0;
            r_enc        <= 1'b0;
            r_K0         <= '0;
            r_T          <= '0;
            r_P          <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_s_fire) begin
                        r_enc <= s_data[0];
                        r_cnt <= '0;
                        if (s_data[1]) begin
                            r_state <= S_KEY;
                        end else begin
                            // Missing key is flagged but the frame proceeds with the all-zero key.
                            if (!r_key_loaded) r_err <= 1'b1;
                            r_state <= S_TWEAK;
                        end
                    end
                end
                S_KEY: begin
                    if (w_s_fire) begin
                        r_K0[W*r_cnt +: W] <= s_data;
                        if (r_cnt == CW'(KW - 1)) begin
                            r_cnt        <= '0;
                            r_key_loaded <= 1'b1;
                            r_state      <= S_TWEAK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_TWEAK: begin
                    if (w_s_fire) begin
                        r_T[W*r_cnt +: W] <= s_data;
                        if (r_cnt == CW'(TW - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_s_fire) begin
                        r_P[W*r_cnt +: W] <= s_data;
                        if (r_cnt == CW'(DW - 1)) begin
                            r_cnt   <= '0;
                            r_wait  <= LW'(CORE_LAT - 1);
                            r_state <= S_WAIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_out   <= core_C;
                        r_oidx  <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_m_fire) begin
                        if (r_oidx == OW'(DW - 1)) begin
                            r_oidx  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_oidx <= r_oidx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blink_word_loader.sv
// Self-checking bench for blink_word_loader: a table of frame descriptors
// followed by randomized frames, all checked against a word-level model.
module tb_blink_word_loader;

    localparam int unsigned N   = 128;
    localparam int unsigned TL  = 128;
    localparam int unsigned RD  = 16;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 16;
    localparam int unsigned KB  = N * RD / 2;
    localparam int unsigned KW  = KB / W;
    localparam int unsigned TW  = TL / W;
    localparam int unsigned DW  = N / W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic          err;
    logic          core_enc;
    logic [KB-1:0] core_K0;
    logic [TL-1:0] core_T;
    logic [N-1:0]  core_P;
    logic [N-1:0]  core_C = '0;

    blink_word_loader #(
        .N(N), .TWEAK_LEN(TL), .ROUND(RD), .W(W), .CORE_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err),
        .core_enc(core_enc), .core_K0(core_K0), .core_T(core_T), .core_P(core_P),
        .core_C(core_C)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int err_cycles = 0;

    // Number of clock cycles in which err is seen high.
    always @(negedge clk) if (err === 1'b1) err_cycles++;

    typedef struct {
        bit          rst_before;
        logic [31:0] hdr;
        bit          exp_err;
        bit          exp_enc;
        bit          seq;
        bit          kstall;
        int unsigned mstall;
        bit          mtoggle;
        int unsigned abort_key;
    } vec_t;

    // Model: key words as last fully loaded, plus whether a key exists.
    logic [W-1:0] m_key [KW];
    bit           m_loaded;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < KW; i++) m_key[i] = '0;
        m_loaded = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_enc", core_enc, 0);
        chk("rst_K0", core_K0, 0);
        chk("rst_T", core_T, 0);
        chk("rst_P", core_P, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit gap);
        bit done;
        done = 1'b0;
        if (gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        for (int c = 0; c < 50 && !done; c++) begin
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic run_frame(input vec_t v);
        logic [W-1:0]  kw [KW];
        logic [W-1:0]  w;
        logic [KB-1:0] expK;
        logic [TL-1:0] expT;
        logic [N-1:0]  expP;
        logic [N-1:0]  base;
        int            e0;
        int            j;
        int            cyc;
        bit            early;

        if (v.rst_before) do_reset();
        e0 = err_cycles;
        send_word(v.hdr, 1'b0);
        chk("err_after_hdr", err, v.exp_err);
        chk("busy_after_hdr", busy, 1);

        if (v.hdr[1]) begin
            for (int i = 0; i < KW; i++) begin
                if (v.abort_key != 0 && i == v.abort_key) begin
                    rst = 1'b0;
                    #2;
                    chk("abort_busy", busy, 0);
                    chk("abort_m_valid", m_valid, 0);
                    chk("abort_K0", core_K0, 0);
                    @(negedge clk);
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    model_clear();
                    return;
                end
                w = v.seq ? W'(i) : W'($urandom);
                kw[i] = w;
                send_word(w, v.kstall);
            end
            for (int i = 0; i < KW; i++) m_key[i] = kw[i];
            m_loaded = 1'b1;
        end

        for (int i = 0; i < TW; i++) begin
            w = v.seq ? 32'h1111_1111 : W'($urandom);
            expT[i*W +: W] = w;
            send_word(w, v.kstall);
        end
        for (int i = 0; i < DW; i++) begin
            w = v.seq ? 32'h2222_2222 : W'($urandom);
            expP[i*W +: W] = w;
            send_word(w, 1'b0);
        end
        chk("s_ready_after_data", s_ready, 0);

        for (int i = 0; i < KW; i++) expK[i*W +: W] = m_key[i];
        chk("core_enc", core_enc, v.exp_enc);
        chk("core_K0", core_K0, expK);
        chk("core_T", core_T, expT);
        chk("core_P", core_P, expP);

        // Only the value present at the CORE_LAT-th edge is the true result.
        base  = v.seq ? {4{32'hA5A5_A5A5}} : {$urandom, $urandom, $urandom, $urandom};
        early = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            core_C = (k == LAT) ? base : (~base ^ N'(k));
            @(posedge clk);
            #1;
            if (k < LAT && m_valid !== 1'b0) early = 1'b1;
            if (k < LAT && s_ready !== 1'b0) early = 1'b1;
        end
        chk("m_valid_early", early, 0);
        chk("latency_m_valid", m_valid, 1);
        chk("hold_K0", core_K0, expK);
        chk("hold_P", core_P, expP);
        core_C = ~base;

        j   = 0;
        cyc = 0;
        while (j < DW && cyc < 200) begin
            if (cyc < v.mstall)  m_ready = 1'b0;
            else if (v.mtoggle)  m_ready = ((cyc - v.mstall) % 2) == 1;
            else                 m_ready = 1'b1;
            chk("out_m_valid", m_valid, 1);
            chk("out_m_data", m_data, base[j*W +: W]);
            chk("out_m_last", m_last, (j == DW - 1));
            chk("out_s_ready", s_ready, 0);
            @(posedge clk);
            #1;
            if (m_ready) j++;
            cyc++;
        end
        m_ready = 1'b0;
        if (j < DW) chk("out_timeout", 0, 1);
        chk("done_busy", busy, 0);
        chk("done_m_valid", m_valid, 0);
        chk("done_s_ready", s_ready, 1);
        chk("err_pulse_count", err_cycles - e0, v.exp_err);
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        model_clear();
        //          rst  hdr            err enc seq kst mst tog abort
        tbl[0] = '{1'b1, 32'h0000_0003, 0, 1, 1, 0, 0,  0, 0};
        tbl[1] = '{1'b0, 32'h0000_0000, 0, 0, 0, 0, 10, 1, 0};
        tbl[2] = '{1'b0, 32'h0000_0002, 0, 0, 0, 1, 0,  0, 0};
        tbl[3] = '{1'b0, 32'hFFFF_FFF1, 0, 1, 0, 0, 3,  0, 0};
        tbl[4] = '{1'b1, 32'h0000_0001, 1, 1, 0, 0, 0,  0, 0};
        tbl[5] = '{1'b0, 32'h0000_0003, 0, 1, 0, 1, 0,  0, 20};
        tbl[6] = '{1'b0, 32'h0000_0000, 1, 0, 0, 0, 0,  1, 0};
        tbl[7] = '{1'b0, 32'h0000_0002, 0, 0, 0, 0, 2,  1, 0};
        for (int f = 0; f < 8; f++) run_frame(tbl[f]);

        for (int r = 0; r < 8; r++) begin
            rv.rst_before = ($urandom_range(0, 4) == 0);
            rv.hdr        = $urandom;
            rv.exp_err    = !rv.hdr[1] && !(m_loaded && !rv.rst_before);
            rv.exp_enc    = rv.hdr[0];
            rv.seq        = 1'b0;
            rv.kstall     = $urandom_range(0, 1) == 1;
            rv.mstall     = $urandom_range(0, 5);
            rv.mtoggle    = $urandom_range(0, 1) == 1;
            rv.abort_key  = 0;
            run_frame(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
